// File: rtl/usb_rx_pkg.sv
// Shared types for the USB 1.1 receive path: receive-buffer FSM states and the
// PID-class codes reported by the RX on rx_packet.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } buf_state_t;

    localparam logic [3:0] RX_PKT_NONE  = 4'd0;
    localparam logic [3:0] RX_PKT_OUT   = 4'd1;
    localparam logic [3:0] RX_PKT_IN    = 4'd2;
    localparam logic [3:0] RX_PKT_SETUP = 4'd3;
    localparam logic [3:0] RX_PKT_DATA0 = 4'd4;
    localparam logic [3:0] RX_PKT_DATA1 = 4'd5;
    localparam logic [3:0] RX_PKT_ACK   = 4'd6;
    localparam logic [3:0] RX_PKT_NAK   = 4'd7;
    localparam logic [3:0] RX_PKT_STALL = 4'd8;

endpackage

// File: rtl/usb_rx_buf_mem.sv
// DEPTH x 8 byte store with synchronous write and a registered read port whose
// output holds its value between reads.
module usb_rx_buf_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array is deliberately left out of reset so it maps onto RAM; only the
    // read register is reset, and the pointers guarantee stale bytes are never served.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Receive-side packet buffer: bytes land speculatively behind wr_ptr, become
// readable only when the packet ends cleanly, and are rolled back otherwise.
module usb_rx_data_buffer
    import usb_rx_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [7:0]      rx_packet_data,
    input  logic            store_rx_packet_data,
    input  logic [3:0]      rx_packet,
    input  logic            rx_transfer_active,
    input  logic            rx_data_ready,
    input  logic            rx_error,
    input  logic            flush,
    input  logic            read_req,
    output logic [7:0]      read_data,
    output logic            read_valid,
    output logic [ADDR_W:0] occupancy,
    output logic            buffer_empty,
    output logic            buffer_full,
    output logic            pkt_done,
    output logic            pkt_dropped,
    output logic [3:0]      last_pid,
    output logic            overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    buf_state_t      state;
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
    logic [ADDR_W:0] total;
    logic            drain_cnt;
    logic            pkt_bad;
    logic            rd_fire, wr_fire, ovf_hit, end_ok, end_bad;

    // Extra pointer bit distinguishes a full buffer from an empty one.
    assign occupancy    = commit_ptr - rd_ptr;
    assign total        = wr_ptr - rd_ptr;
    assign buffer_empty = (occupancy == '0);
    assign buffer_full  = (total == DEPTH_CNT);

    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        rd_fire = read_req && !buffer_empty;
        wr_fire = 1'b0;
        ovf_hit = 1'b0;
        end_ok  = 1'b0;
        end_bad = 1'b0;
        if (state != IDLE) begin
            if (rx_data_ready) begin
                end_ok  = !pkt_bad;
                end_bad = pkt_bad;
            end else if (rx_error) begin
                end_bad = 1'b1;
            end else if (state == DRAIN && drain_cnt) begin
                end_bad = 1'b1;
            end else if (state == RECV && store_rx_packet_data) begin
                wr_fire = !buffer_full;
                ovf_hit = buffer_full;
            end
        end
    end

    usb_rx_buf_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (wr_fire && !flush),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (rx_packet_data),
        .rd_en   (rd_fire && !flush),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (read_data)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            drain_cnt   <= 1'b0;
            pkt_bad     <= 1'b0;
            read_valid  <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_dropped <= 1'b0;
            last_pid    <= 4'd0;
            overflow    <= 1'b0;
        end else begin
            read_valid  <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_dropped <= 1'b0;
            if (flush) begin
                state      <= IDLE;
                wr_ptr     <= '0;
                commit_ptr <= '0;
                rd_ptr     <= '0;
                pkt_bad    <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (rd_fire) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    read_valid <= 1'b1;
                end
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (ovf_hit) begin
                    overflow <= 1'b1;
                    pkt_bad  <= 1'b1;
                end
                if (end_ok) begin
                    commit_ptr <= wr_ptr;
                    last_pid   <= rx_packet;
                    pkt_done   <= 1'b1;
                end
                if (end_bad) begin
                    wr_ptr      <= commit_ptr;
                    pkt_dropped <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (rx_transfer_active) begin
                            state   <= RECV;
                            pkt_bad <= 1'b0;
                        end
                    end
                    RECV: begin
                        if (end_ok || end_bad) begin
                            state <= IDLE;
                        end else if (!rx_transfer_active) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        // End-of-packet pulse may trail the active flag by up to two cycles.
                        if (end_ok || end_bad) begin
                            state <= IDLE;
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Bench for usb_rx_data_buffer: directed scenarios plus randomized packet traffic,
// all compared against a queue-based model of committed and pending bytes.
module tb_usb_rx_data_buffer;
    import usb_rx_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int M_IDLE = 0, M_RECV = 1, M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  rx_packet_data;
    logic        store_rx_packet_data;
    logic [3:0]  rx_packet;
    logic        rx_transfer_active, rx_data_ready, rx_error, flush, read_req;
    logic [7:0]  read_data;
    logic        read_valid;
    logic [AW:0] occupancy;
    logic        buffer_empty, buffer_full, pkt_done, pkt_dropped;
    logic [3:0]  last_pid;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queues instead of pointers.
    logic [7:0] comm_q[$];
    logic [7:0] pend_q[$];
    int         m_mode, m_drain;
    bit         m_bad, m_ovf, m_rv, m_done, m_drop;
    logic [3:0] m_pid;
    logic [7:0] m_rd;

    always #5 clk = ~clk;

    usb_rx_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet            (rx_packet),
        .rx_transfer_active   (rx_transfer_active),
        .rx_data_ready        (rx_data_ready),
        .rx_error             (rx_error),
        .flush                (flush),
        .read_req             (read_req),
        .read_data            (read_data),
        .read_valid           (read_valid),
        .occupancy            (occupancy),
        .buffer_empty         (buffer_empty),
        .buffer_full          (buffer_full),
        .pkt_done             (pkt_done),
        .pkt_dropped          (pkt_dropped),
        .last_pid             (last_pid),
        .overflow             (overflow)
    );

    // Advance the model by the current inputs, clock the DUT, clear one-cycle strobes.
    task automatic step();
        bit full, do_commit, do_drop;
        m_rv = 0; m_done = 0; m_drop = 0;
        do_commit = 0; do_drop = 0;
        if (!n_rst) begin
            comm_q.delete(); pend_q.delete();
            m_mode = M_IDLE; m_bad = 0; m_ovf = 0; m_pid = 4'd0; m_rd = 8'h00;
        end else if (flush) begin
            comm_q.delete(); pend_q.delete();
            m_mode = M_IDLE; m_ovf = 0;
        end else begin
            full = (comm_q.size() + pend_q.size()) == DEPTH;
            if (read_req && comm_q.size() != 0) begin
                m_rv = 1;
                m_rd = comm_q.pop_front();
            end
            if (m_mode == M_IDLE) begin
                if (rx_transfer_active) begin m_mode = M_RECV; m_bad = 0; end
            end else begin
                if (rx_data_ready) begin
                    if (m_bad) do_drop = 1; else do_commit = 1;
                end else if (rx_error) begin
                    do_drop = 1;
                end else if (m_mode == M_RECV) begin
                    if (store_rx_packet_data) begin
                        if (full) begin m_ovf = 1; m_bad = 1; end
                        else pend_q.push_back(rx_packet_data);
                    end
                    if (!rx_transfer_active) begin m_mode = M_DRAIN; m_drain = 0; end
                end else begin
                    m_drain++;
                    if (m_drain == 2) do_drop = 1;
                end
                if (do_commit) begin
                    while (pend_q.size() != 0) comm_q.push_back(pend_q.pop_front());
                    m_pid = rx_packet; m_done = 1; m_mode = M_IDLE;
                end
                if (do_drop) begin
                    pend_q.delete(); m_drop = 1; m_mode = M_IDLE;
                end
            end
        end
        @(posedge clk);
        #1;
        store_rx_packet_data = 0; rx_data_ready = 0; rx_error = 0; flush = 0; read_req = 0;
    endtask

    task automatic start_pkt();
        rx_transfer_active = 1; step();
    endtask

    task automatic put_byte(input logic [7:0] b);
        store_rx_packet_data = 1; rx_packet_data = b; step();
    endtask

    task automatic end_good(input logic [3:0] pid);
        rx_data_ready = 1; rx_transfer_active = 0; rx_packet = pid; step();
    endtask

    task automatic test_reset();
        n_rst = 0; rx_packet_data = 0; store_rx_packet_data = 0; rx_packet = 0;
        rx_transfer_active = 0; rx_data_ready = 0; rx_error = 0; flush = 0; read_req = 0;
        step(); step();
        n_checks++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_read_data: got %0h expected 0", read_data); end
        n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_read_valid: got %0b expected 0", read_valid); end
        n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_checks++; if (buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1/0", buffer_empty, buffer_full); end
        n_checks++; if (pkt_done !== 1'b0 || pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%0b dropped=%0b expected 0/0", pkt_done, pkt_dropped); end
        n_checks++; if (last_pid !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_pid_ovf: got pid=%0d ovf=%0b expected 0/0", last_pid, overflow); end
        n_rst = 1; step();
    endtask

    task automatic test_data0();
        start_pkt();
        for (int i = 0; i < 5; i++) put_byte(8'(8'h11 * (i + 1)));
        end_good(RX_PKT_DATA0);
        n_checks++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL data0_done: got %0b expected 1", pkt_done); end
        n_checks++; if (occupancy !== 7'd5) begin n_fail++; $display("FAIL data0_occupancy: got %0d expected 5", occupancy); end
        n_checks++; if (last_pid !== 4'd4) begin n_fail++; $display("FAIL data0_pid: got %0d expected 4", last_pid); end
        step();
        n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL data0_done_pulse: got %0b expected 0", pkt_done); end
        for (int i = 0; i < 5; i++) begin
            read_req = 1; step();
            n_checks++;
            if (read_valid !== 1'b1 || read_data !== 8'(8'h11 * (i + 1))) begin
                n_fail++; $display("FAIL data0_read%0d: got valid=%0b data=%0h expected 1/%0h", i, read_valid, read_data, 8'(8'h11 * (i + 1)));
            end
        end
        step();
        n_checks++; if (read_valid !== 1'b0 || read_data !== 8'h55) begin n_fail++; $display("FAIL data0_hold: got valid=%0b data=%0h expected 0/55", read_valid, read_data); end
        read_req = 1; step();
        n_checks++; if (read_valid !== 1'b0 || buffer_empty !== 1'b1) begin n_fail++; $display("FAIL read_when_empty: got valid=%0b empty=%0b expected 0/1", read_valid, buffer_empty); end
    endtask

    task automatic test_error();
        logic [7:0] b [2];
        start_pkt();
        for (int i = 0; i < 3; i++) put_byte(8'($urandom));
        rx_error = 1; rx_transfer_active = 0; step();
        n_checks++; if (pkt_dropped !== 1'b1 || pkt_done !== 1'b0) begin n_fail++; $display("FAIL error_drop: got dropped=%0b done=%0b expected 1/0", pkt_dropped, pkt_done); end
        n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL error_occupancy: got %0d expected 0", occupancy); end
        start_pkt();
        for (int i = 0; i < 2; i++) begin b[i] = 8'($urandom); put_byte(b[i]); end
        end_good(RX_PKT_DATA1);
        n_checks++; if (occupancy !== 7'd2) begin n_fail++; $display("FAIL error_next_occupancy: got %0d expected 2", occupancy); end
        for (int i = 0; i < 2; i++) begin
            read_req = 1; step();
            n_checks++; if (read_data !== b[i]) begin n_fail++; $display("FAIL error_next_data%0d: got %0h expected %0h", i, read_data, b[i]); end
        end
    endtask

    task automatic test_overflow();
        start_pkt();
        for (int i = 0; i < DEPTH; i++) put_byte(8'($urandom));
        n_checks++; if (buffer_full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full64: got full=%0b ovf=%0b expected 1/0", buffer_full, overflow); end
        put_byte(8'hEE);
        n_checks++; if (overflow !== 1'b1 || occupancy !== 7'd0) begin n_fail++; $display("FAIL ovf_65th: got ovf=%0b occ=%0d expected 1/0", overflow, occupancy); end
        end_good(RX_PKT_DATA0);
        n_checks++; if (pkt_dropped !== 1'b1 || pkt_done !== 1'b0) begin n_fail++; $display("FAIL ovf_drop: got dropped=%0b done=%0b expected 1/0", pkt_dropped, pkt_done); end
        n_checks++; if (occupancy !== 7'd0 || buffer_full !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got occ=%0d full=%0b ovf=%0b expected 0/0/1", occupancy, buffer_full, overflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] b [60];
        start_pkt();
        for (int i = 0; i < 60; i++) begin b[i] = 8'($urandom); put_byte(b[i]); end
        end_good(RX_PKT_DATA0);
        n_checks++; if (occupancy !== 7'd60) begin n_fail++; $display("FAIL wrap_occ60: got %0d expected 60", occupancy); end
        for (int i = 0; i < 60; i++) begin
            read_req = 1; step();
            n_checks++; if (read_data !== b[i]) begin n_fail++; $display("FAIL wrap_read%0d: got %0h expected %0h", i, read_data, b[i]); end
        end
        start_pkt();
        for (int i = 0; i < 10; i++) begin b[i] = 8'($urandom); put_byte(b[i]); end
        end_good(RX_PKT_DATA1);
        n_checks++; if (occupancy !== 7'd10) begin n_fail++; $display("FAIL wrap_occ10: got %0d expected 10", occupancy); end
        for (int i = 0; i < 10; i++) begin
            read_req = 1; step();
            n_checks++; if (read_data !== b[i]) begin n_fail++; $display("FAIL wrap_second_read%0d: got %0h expected %0h", i, read_data, b[i]); end
        end
    endtask

    task automatic test_flush();
        start_pkt();
        for (int i = 0; i < 4; i++) put_byte(8'($urandom));
        end_good(RX_PKT_DATA0);
        start_pkt();
        for (int i = 0; i < 3; i++) put_byte(8'($urandom));
        n_checks++; if (occupancy !== 7'd4) begin n_fail++; $display("FAIL flush_pre_occ: got %0d expected 4", occupancy); end
        flush = 1; rx_transfer_active = 0; read_req = 1; step();
        n_checks++; if (occupancy !== 7'd0 || buffer_empty !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush_state: got occ=%0d empty=%0b ovf=%0b expected 0/1/0", occupancy, buffer_empty, overflow); end
        n_checks++; if (pkt_done !== 1'b0 || pkt_dropped !== 1'b0 || read_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pulses: got done=%0b dropped=%0b rv=%0b expected 0/0/0", pkt_done, pkt_dropped, read_valid); end
        step(); step(); step();
        n_checks++; if (pkt_done !== 1'b0 || pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL flush_no_late_pulse: got done=%0b dropped=%0b expected 0/0", pkt_done, pkt_dropped); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a0, a1, p0;
        a0 = 8'($urandom); a1 = 8'($urandom); p0 = 8'($urandom);
        start_pkt(); put_byte(a0); put_byte(a1); end_good(RX_PKT_DATA0);
        start_pkt(); put_byte(p0);
        store_rx_packet_data = 1; rx_packet_data = ~p0; rx_data_ready = 1;
        rx_transfer_active = 0; read_req = 1; rx_packet = RX_PKT_DATA1; step();
        n_checks++; if (occupancy !== 7'd2) begin n_fail++; $display("FAIL same_cycle_occ: got %0d expected 2", occupancy); end
        n_checks++; if (read_valid !== 1'b1 || read_data !== a0 || pkt_done !== 1'b1) begin n_fail++; $display("FAIL same_cycle_read: got rv=%0b data=%0h done=%0b expected 1/%0h/1", read_valid, read_data, pkt_done, a0); end
        read_req = 1; step();
        read_req = 1; step();
        n_checks++; if (read_data !== p0 || buffer_empty !== 1'b1) begin n_fail++; $display("FAIL same_cycle_tail: got data=%0h empty=%0b expected %0h/1", read_data, buffer_empty, p0); end
    endtask

    task automatic test_drain();
        start_pkt(); end_good(RX_PKT_ACK);
        n_checks++; if (pkt_done !== 1'b1 || last_pid !== 4'd6 || occupancy !== 7'd0) begin n_fail++; $display("FAIL zero_len: got done=%0b pid=%0d occ=%0d expected 1/6/0", pkt_done, last_pid, occupancy); end
        start_pkt(); put_byte(8'($urandom)); put_byte(8'($urandom));
        rx_transfer_active = 0; step(); step();
        n_checks++; if (pkt_done !== 1'b0 || pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL drain_wait: got done=%0b dropped=%0b expected 0/0", pkt_done, pkt_dropped); end
        rx_data_ready = 1; rx_packet = RX_PKT_DATA0; step();
        n_checks++; if (pkt_done !== 1'b1 || occupancy !== 7'd2 || last_pid !== 4'd4) begin n_fail++; $display("FAIL drain_late_ready: got done=%0b occ=%0d pid=%0d expected 1/2/4", pkt_done, occupancy, last_pid); end
        read_req = 1; step(); read_req = 1; step();
        start_pkt(); put_byte(8'($urandom));
        rx_transfer_active = 0; step(); step();
        n_checks++; if (pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL drain_early_timeout: got dropped=%0b expected 0", pkt_dropped); end
        step();
        n_checks++; if (pkt_dropped !== 1'b1 || occupancy !== 7'd0) begin n_fail++; $display("FAIL drain_timeout: got dropped=%0b occ=%0d expected 1/0", pkt_dropped, occupancy); end
    endtask

    task automatic test_random();
        bit in_pkt, late_ready;
        int left, kind;
        in_pkt = 0; late_ready = 0; left = 0;
        for (int c = 0; c < 1500; c++) begin
            read_req = ($urandom_range(0, 2) == 0);
            if (late_ready) begin
                rx_data_ready = 1; rx_packet = 4'($urandom_range(0, 8)); late_ready = 0;
            end else if (!in_pkt) begin
                if ($urandom_range(0, 3) == 0) begin
                    rx_transfer_active = 1; in_pkt = 1;
                    left = ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(0, 24);
                end
            end else if (left > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    store_rx_packet_data = 1; rx_packet_data = 8'($urandom); left--;
                end
            end else begin
                kind = $urandom_range(0, 9);
                rx_packet = 4'($urandom_range(0, 8));
                if (kind < 6) rx_data_ready = 1;
                else if (kind < 8) rx_error = 1;
                else if (kind == 8) late_ready = 1;
                rx_transfer_active = 0; in_pkt = 0;
            end
            if ($urandom_range(0, 199) == 0) flush = 1;
            step();
            n_checks++; if (occupancy !== 7'(comm_q.size())) begin n_fail++; $display("FAIL rnd_occupancy c%0d: got %0d expected %0d", c, occupancy, comm_q.size()); end
            n_checks++; if (buffer_empty !== (comm_q.size() == 0) || buffer_full !== ((comm_q.size() + pend_q.size()) == DEPTH)) begin n_fail++; $display("FAIL rnd_flags c%0d: got empty=%0b full=%0b expected %0b/%0b", c, buffer_empty, buffer_full, comm_q.size() == 0, (comm_q.size() + pend_q.size()) == DEPTH); end
            n_checks++; if (read_valid !== m_rv || read_data !== m_rd) begin n_fail++; $display("FAIL rnd_read c%0d: got rv=%0b data=%0h expected %0b/%0h", c, read_valid, read_data, m_rv, m_rd); end
            n_checks++; if (pkt_done !== m_done || pkt_dropped !== m_drop) begin n_fail++; $display("FAIL rnd_pulses c%0d: got done=%0b dropped=%0b expected %0b/%0b", c, pkt_done, pkt_dropped, m_done, m_drop); end
            n_checks++; if (last_pid !== m_pid || overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_pid_ovf c%0d: got pid=%0d ovf=%0b expected %0d/%0b", c, last_pid, overflow, m_pid, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_data0();
        test_error();
        test_overflow();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
